// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter sharing the TCP stack transmit port among NUM_APPS requesters.
// Granted IDs enter an in-order FIFO so each returned tx status goes back to its issuer.
module tcp_tx_arbiter #(
  parameter int unsigned NUM_APPS      = 4,
  parameter int unsigned WIDTH         = 512,
  parameter int unsigned META_WIDTH    = 32,
  parameter int unsigned STATUS_WIDTH  = 64,
  parameter int unsigned ID_FIFO_DEPTH = 16
) (
  input  logic                             net_clk,
  input  logic                             net_areset,
  input  logic [NUM_APPS-1:0]              s_meta_valid,
  output logic [NUM_APPS-1:0]              s_meta_ready,
  input  logic [NUM_APPS*META_WIDTH-1:0]   s_meta_data,
  input  logic [NUM_APPS-1:0]              s_data_valid,
  output logic [NUM_APPS-1:0]              s_data_ready,
  input  logic [NUM_APPS*WIDTH-1:0]        s_data_data,
  input  logic [NUM_APPS*(WIDTH/8)-1:0]    s_data_keep,
  input  logic [NUM_APPS-1:0]              s_data_last,
  output logic                             m_meta_valid,
  input  logic                             m_meta_ready,
  output logic [META_WIDTH-1:0]            m_meta_data,
  output logic                             m_data_valid,
  input  logic                             m_data_ready,
  output logic [WIDTH-1:0]                 m_data_data,
  output logic [WIDTH/8-1:0]               m_data_keep,
  output logic                             m_data_last,
  input  logic                             s_sts_valid,
  output logic                             s_sts_ready,
  input  logic [STATUS_WIDTH-1:0]          s_sts_data,
  output logic [NUM_APPS-1:0]              m_sts_valid,
  input  logic [NUM_APPS-1:0]              m_sts_ready,
  output logic [STATUS_WIDTH-1:0]          m_sts_data,
  output logic                             sts_orphan
);

  localparam int unsigned IDW = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
  localparam int unsigned KW  = WIDTH / 8;
  localparam int unsigned PW  = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;

  typedef enum logic [1:0] {IDLE, META, DATA} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] w_rr_pick;
  logic [IDW-1:0] w_rr_idx;
  logic           w_rr_found;
  logic           w_arb;
  logic           w_can_grant;
  logic           w_meta_hs;
  logic           w_data_hs;

  logic [IDW-1:0] r_fifo [ID_FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_fifo_empty;
  logic           w_fifo_full;
  logic           w_push;
  logic           w_pop;
  logic [IDW-1:0] w_head;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CW'(ID_FIFO_DEPTH));
  assign w_head       = r_fifo[r_rd_ptr];
  // A pop in the arbitration cycle frees a slot in time for the next push
  assign w_can_grant  = !w_fifo_full || w_pop;
  assign w_arb        = (r_state == IDLE) && w_rr_found && w_can_grant;

  // First valid requester searching upward from last_grant+1, wrapping
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = r_last_grant;
    w_rr_idx   = '0;
    for (int i = 1; i <= int'(NUM_APPS); i++) begin
      w_rr_idx = IDW'((int'(r_last_grant) + i) % int'(NUM_APPS));
      if (!w_rr_found && s_meta_valid[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = w_rr_idx;
      end
    end
  end

  // Next state and combinational pass-through of the granted requester
  always_comb begin
    w_state_next = r_state;
    s_meta_ready = '0;
    s_data_ready = '0;
    m_meta_valid = 1'b0;
    m_meta_data  = '0;
    m_data_valid = 1'b0;
    m_data_data  = '0;
    m_data_keep  = '0;
    m_data_last  = 1'b0;
    w_meta_hs    = 1'b0;
    w_data_hs    = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb) w_state_next = META;
      end
      META: begin
        m_meta_valid          = s_meta_valid[r_grant];
        m_meta_data           = s_meta_data[int'(r_grant)*META_WIDTH +: META_WIDTH];
        s_meta_ready[r_grant] = m_meta_ready;
        w_meta_hs             = s_meta_valid[r_grant] && m_meta_ready;
        w_push                = w_meta_hs;
        if (w_meta_hs) w_state_next = DATA;
      end
      DATA: begin
        m_data_valid          = s_data_valid[r_grant];
        m_data_data           = s_data_data[int'(r_grant)*WIDTH +: WIDTH];
        m_data_keep           = s_data_keep[int'(r_grant)*KW +: KW];
        m_data_last           = s_data_last[r_grant];
        s_data_ready[r_grant] = m_data_ready;
        w_data_hs             = s_data_valid[r_grant] && m_data_ready;
        if (w_data_hs && s_data_last[r_grant]) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Status return path; held quiet while reset is asserted
  always_comb begin
    m_sts_valid = '0;
    m_sts_data  = '0;
    s_sts_ready = 1'b0;
    sts_orphan  = 1'b0;
    w_pop       = 1'b0;
    if (!net_areset) begin
      m_sts_data = s_sts_data;
      if (w_fifo_empty) begin
        s_sts_ready = 1'b1;
        sts_orphan  = s_sts_valid;
      end else begin
        m_sts_valid[w_head] = s_sts_valid;
        s_sts_ready         = m_sts_ready[w_head];
        w_pop               = s_sts_valid && m_sts_ready[w_head];
      end
    end
  end

  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= IDW'(NUM_APPS - 1);
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_arb) begin
        r_grant      <= w_rr_pick;
        r_last_grant <= w_rr_pick;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ID storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge net_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_grant;
  end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Randomized bench for tcp_tx_arbiter: a packet/status scoreboard predicts round-robin
// grant order, beat stream and status routing; directed scenarios cover corner cases.
module tb_tcp_tx_arbiter;

  localparam int unsigned NA = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned KW = W / 8;
  localparam int unsigned MW = 32;
  localparam int unsigned SW = 64;
  localparam int unsigned D  = 16;

  logic                 net_clk;
  logic                 net_areset;
  logic [NA-1:0]        s_meta_valid, s_meta_ready, s_data_valid, s_data_ready, s_data_last;
  logic [NA*MW-1:0]     s_meta_data;
  logic [NA*W-1:0]      s_data_data;
  logic [NA*KW-1:0]     s_data_keep;
  logic                 m_meta_valid, m_meta_ready;
  logic [MW-1:0]        m_meta_data;
  logic                 m_data_valid, m_data_ready, m_data_last;
  logic [W-1:0]         m_data_data;
  logic [KW-1:0]        m_data_keep;
  logic                 s_sts_valid, s_sts_ready, sts_orphan;
  logic [SW-1:0]        s_sts_data, m_sts_data;
  logic [NA-1:0]        m_sts_valid, m_sts_ready;

  tcp_tx_arbiter #(
    .NUM_APPS(NA), .WIDTH(W), .META_WIDTH(MW), .STATUS_WIDTH(SW), .ID_FIFO_DEPTH(D)
  ) dut (
    .net_clk(net_clk), .net_areset(net_areset),
    .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_data(s_meta_data),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
    .s_data_keep(s_data_keep), .s_data_last(s_data_last),
    .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready), .m_meta_data(m_meta_data),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_data(m_data_data),
    .m_data_keep(m_data_keep), .m_data_last(m_data_last),
    .s_sts_valid(s_sts_valid), .s_sts_ready(s_sts_ready), .s_sts_data(s_sts_data),
    .m_sts_valid(m_sts_valid), .m_sts_ready(m_sts_ready), .m_sts_data(m_sts_data),
    .sts_orphan(sts_orphan)
  );

  initial net_clk = 1'b0;
  always #5 net_clk = ~net_clk;

  typedef struct {
    int            app;
    bit            is_meta;
    logic [MW-1:0] meta;
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } item_t;

  item_t         exp_q[$];
  int            sts_q[$];
  int            model_last;
  int            pkt_len[NA];
  logic [MW-1:0] pkt_meta[NA];
  logic [W-1:0]  bdata[NA][8];
  logic [KW-1:0] bkeep[NA][8];
  int            beat_idx[NA];
  bit            meta_done[NA];
  bit            active[NA];
  int            n_pass;
  int            n_total;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [NA-1:0] oh(input int a);
    return NA'(1) << a;
  endfunction

  task automatic clear_inputs();
    s_meta_valid = '0; s_meta_data = '0;
    s_data_valid = '0; s_data_data = '0; s_data_keep = '0; s_data_last = '0;
    m_meta_ready = 1'b0; m_data_ready = 1'b0;
    s_sts_valid = 1'b0; s_sts_data = '0; m_sts_ready = '0;
  endtask

  task automatic drive_apps();
    for (int a = 0; a < int'(NA); a++) begin
      s_meta_valid[a] = active[a] && !meta_done[a];
      s_data_valid[a] = active[a] && meta_done[a];
      s_meta_data[a*MW +: MW] = active[a] ? pkt_meta[a] : MW'($urandom);
      s_data_data[a*W +: W]   = active[a] ? bdata[a][beat_idx[a]] : {$urandom, $urandom};
      s_data_keep[a*KW +: KW] = active[a] ? bkeep[a][beat_idx[a]] : KW'($urandom);
      s_data_last[a]          = active[a] ? (beat_idx[a] == pkt_len[a] - 1) : 1'($urandom);
    end
  endtask

  // One round: every app in mask presents one packet and holds it until served.
  task automatic run_round(input logic [NA-1:0] mask, input int rdy_mode,
                           input bit sts_en, input bit drain);
    int    order[$];
    int    a, cyc, gap;
    bit    gf, meta_hs, data_hs, sts_pop;
    item_t it;
    for (int i = 1; i <= int'(NA); i++) begin
      a = (model_last + i) % int'(NA);
      if (mask[a]) order.push_back(a);
    end
    if (order.size() > 0) model_last = order[order.size()-1];
    foreach (order[k]) begin
      a = order[k];
      active[a] = 1'b1; meta_done[a] = 1'b0; beat_idx[a] = 0;
      exp_q.push_back('{app: a, is_meta: 1'b1, meta: pkt_meta[a], data: '0, keep: '0, last: 1'b0});
      for (int b = 0; b < pkt_len[a]; b++) begin
        bdata[a][b] = {$urandom, $urandom};
        bkeep[a][b] = KW'($urandom);
        exp_q.push_back('{app: a, is_meta: 1'b0, meta: '0, data: bdata[a][b],
                          keep: bkeep[a][b], last: (b == pkt_len[a] - 1)});
      end
    end
    gap = 1; gf = 1'b0; cyc = 0;
    while (exp_q.size() > 0 || (drain && sts_q.size() > 0)) begin
      if (cyc == 1000) begin
        check("round_timeout", 64'(exp_q.size() + sts_q.size()), 64'd0);
        exp_q.delete();
        for (int i = 0; i < int'(NA); i++) active[i] = 1'b0;
        break;
      end
      @(negedge net_clk);
      drive_apps();
      m_data_ready = (rdy_mode == 0) ? 1'($urandom) : (rdy_mode == 1) ? (cyc % 2 == 0) : 1'b1;
      m_meta_ready = (rdy_mode == 0) ? 1'($urandom) : 1'b1;
      s_sts_valid  = sts_en && (sts_q.size() > 0) && ($urandom_range(1, 0) == 1);
      s_sts_data   = {$urandom, $urandom};
      m_sts_ready  = (rdy_mode == 0) ? NA'($urandom) : '1;
      #4;
      // status routing
      check("sts_valid", m_sts_valid,
            (s_sts_valid && sts_q.size() > 0) ? oh(sts_q[0]) : '0);
      check("sts_orphan", sts_orphan, s_sts_valid && sts_q.size() == 0);
      sts_pop = 1'b0;
      if (sts_q.size() > 0) begin
        check("sts_ready", s_sts_ready, m_sts_ready[sts_q[0]]);
        if (s_sts_valid && m_sts_ready[sts_q[0]]) begin
          check("sts_data", m_sts_data, s_sts_data);
          sts_pop = 1'b1;
        end
      end else check("sts_ready_empty", s_sts_ready, 1'b1);
      // transmit side against the expected beat stream
      meta_hs = 1'b0; data_hs = 1'b0;
      if (exp_q.size() == 0) begin
        check("idle_meta_valid", m_meta_valid, 1'b0);
        check("idle_data_valid", m_data_valid, 1'b0);
        check("idle_readies", {s_meta_ready, s_data_ready}, '0);
      end else begin
        it = exp_q[0];
        if (it.is_meta) begin
          check("data_valid_pre_meta", m_data_valid, 1'b0);
          check("data_ready_pre_meta", s_data_ready, '0);
          if (m_meta_valid) check("meta_data", m_meta_data, it.meta);
          check("meta_ready", s_meta_ready, (m_meta_valid && m_meta_ready) ? oh(it.app) : '0);
          meta_hs = m_meta_valid && m_meta_ready;
        end else begin
          check("meta_valid_in_data", m_meta_valid, 1'b0);
          check("meta_ready_in_data", s_meta_ready, '0);
          check("data_valid", m_data_valid, 1'b1);
          check("data_ready", s_data_ready, m_data_ready ? oh(it.app) : '0);
          if (m_data_ready) begin
            check("data_data", m_data_data, it.data);
            check("data_keep", m_data_keep, it.keep);
            check("data_last", m_data_last, it.last);
            data_hs = 1'b1;
          end
        end
      end
      // one idle cycle after last / round start, then meta the following cycle
      if (gap == 1) begin
        check("idle_gap", m_meta_valid, 1'b0);
        gf = sts_q.size() < int'(D);
      end else if (gap == 2 && exp_q.size() > 0 && exp_q[0].is_meta && gf) begin
        check("arb_latency", m_meta_valid, 1'b1);
      end
      if (gap > 0 && gap < 3) gap++;
      if (meta_hs) begin
        meta_done[it.app] = 1'b1;
        void'(exp_q.pop_front());
      end
      if (data_hs) begin
        void'(exp_q.pop_front());
        if (it.last) begin
          active[it.app] = 1'b0;
          gap = 1;
        end else beat_idx[it.app]++;
      end
      if (sts_pop) void'(sts_q.pop_front());
      if (meta_hs) sts_q.push_back(it.app);
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_meta_valid"}, m_meta_valid, 1'b0);
    check({tag, "_data_valid"}, m_data_valid, 1'b0);
    check({tag, "_readies"}, {s_meta_ready, s_data_ready, s_sts_ready}, '0);
    check({tag, "_sts_valid"}, m_sts_valid, '0);
    check({tag, "_orphan"}, sts_orphan, 1'b0);
    check({tag, "_data_out"}, m_data_data, '0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0;
    model_last = int'(NA) - 1;
    for (int a = 0; a < int'(NA); a++) begin
      active[a] = 1'b0; meta_done[a] = 1'b0; beat_idx[a] = 0; pkt_len[a] = 1; pkt_meta[a] = '0;
    end
    clear_inputs();
    net_areset = 1'b1;
    s_sts_valid = 1'b1;
    repeat (2) @(negedge net_clk);
    #4;
    check_all_zero("reset");
    @(negedge net_clk);
    s_sts_valid = 1'b0;
    net_areset = 1'b0;
    #4;
    check("post_reset_sts_ready", s_sts_ready, 1'b1);

    // round robin from reset: 0,1,3 then 0,1,3 again
    for (int r = 0; r < 2; r++) begin
      foreach (pkt_len[a]) begin
        pkt_len[a] = $urandom_range(3, 1);
        pkt_meta[a] = {16'($urandom_range(200, 0)), 16'(a)};
      end
      run_round(4'b1011, 2, 1'b1, r == 1);
    end

    // single requester app 2, then status 0x1 routed only to app 2
    pkt_len[2] = 2; pkt_meta[2] = 32'h0040_0005;
    run_round(4'b0100, 2, 1'b0, 1'b0);
    @(negedge net_clk);
    clear_inputs();
    s_sts_valid = 1'b1; s_sts_data = 64'h1; m_sts_ready = '1;
    #4;
    check("single_sts_valid", m_sts_valid, 4'b0100);
    check("single_sts_data", m_sts_data, 64'h1);
    check("single_sts_ready", s_sts_ready, 1'b1);
    void'(sts_q.pop_front());

    // backpressure 1010 on a 4-beat packet from app 1
    pkt_len[1] = 4; pkt_meta[1] = 32'h0100_0011;
    run_round(4'b0010, 1, 1'b1, 1'b1);

    // fill the ID FIFO with 16 unanswered packets
    for (int r = 0; r < 4; r++) begin
      foreach (pkt_len[a]) begin pkt_len[a] = 1; pkt_meta[a] = $urandom; end
      run_round(4'b1111, 2, 1'b0, 1'b0);
    end
    @(negedge net_clk);
    clear_inputs();
    s_meta_valid = 4'b0001; s_meta_data[MW-1:0] = 32'h0001_00AA; m_meta_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #4;
      check("full_blocks_grant", m_meta_valid, 1'b0);
      @(negedge net_clk);
    end
    s_sts_valid = 1'b1; s_sts_data = 64'h55; m_sts_ready = '1;
    #4;
    check("full_pop_route", m_sts_valid, oh(sts_q[0]));
    void'(sts_q.pop_front());
    @(negedge net_clk);
    s_sts_valid = 1'b0;
    #4;
    check("grant_after_pop", m_meta_valid, 1'b1);
    check("grant_after_pop_data", m_meta_data, 32'h0001_00AA);
    sts_q.push_back(0);
    model_last = 0;
    @(negedge net_clk);
    clear_inputs();
    s_data_valid = 4'b0001; s_data_data[W-1:0] = 64'hDEAD_0000_0000_0017;
    s_data_keep[KW-1:0] = 8'hFF; s_data_last = 4'b0001; m_data_ready = 1'b1;
    #4;
    check("full_last_beat", m_data_data, 64'hDEAD_0000_0000_0017);
    run_round(4'b0000, 0, 1'b1, 1'b1);

    // orphan status with an empty FIFO
    @(negedge net_clk);
    clear_inputs();
    s_sts_valid = 1'b1; s_sts_data = 64'hABC;
    #4;
    check("orphan_ready", s_sts_ready, 1'b1);
    check("orphan_pulse", sts_orphan, 1'b1);
    check("orphan_no_valid", m_sts_valid, '0);
    @(negedge net_clk);
    s_sts_valid = 1'b0;
    #4;
    check("orphan_clears", sts_orphan, 1'b0);

    // push and pop in the same cycle keep one entry outstanding
    pkt_len[1] = 1; pkt_meta[1] = 32'h0000_0101;
    run_round(4'b0010, 2, 1'b0, 1'b0);
    @(negedge net_clk);
    clear_inputs();
    s_meta_valid = 4'b0100; s_meta_data[2*MW +: MW] = 32'h0000_0202; m_meta_ready = 1'b1;
    #4;
    check("pp_idle", m_meta_valid, 1'b0);
    @(negedge net_clk);
    s_sts_valid = 1'b1; m_sts_ready = '1;
    #4;
    check("pp_meta", m_meta_valid, 1'b1);
    check("pp_sts_head", m_sts_valid, 4'b0010);
    @(negedge net_clk);
    clear_inputs();
    s_data_valid = 4'b0100; s_data_last = 4'b0100; m_data_ready = 1'b1;
    #4;
    check("pp_data", m_data_valid, 1'b1);
    @(negedge net_clk);
    clear_inputs();
    s_sts_valid = 1'b1; m_sts_ready = '1;
    #4;
    check("pp_new_head", m_sts_valid, 4'b0100);
    @(negedge net_clk);
    #4;
    check("pp_then_empty", sts_orphan, 1'b1);
    sts_q.delete();
    model_last = 2;

    // randomized rounds with concurrent status returns
    for (int r = 0; r < 25; r++) begin
      foreach (pkt_len[a]) begin
        pkt_len[a] = $urandom_range(5, 1);
        pkt_meta[a] = $urandom;
      end
      run_round(NA'($urandom), $urandom_range(2, 0), 1'b1, r == 24);
    end

    // reset during beat 2 of a 4-beat packet
    @(negedge net_clk);
    clear_inputs();
    s_meta_valid = 4'b0010; s_meta_data[MW +: MW] = 32'h0100_0001;
    m_meta_ready = 1'b1; m_data_ready = 1'b1;
    #4;
    check("rst_seq_idle", m_meta_valid, 1'b0);
    @(negedge net_clk);
    #4;
    check("rst_seq_meta", m_meta_valid, 1'b1);
    @(negedge net_clk);
    s_meta_valid = '0; s_data_valid = 4'b0010; s_data_data[W +: W] = 64'h1111;
    #4;
    check("rst_seq_beat1", m_data_data, 64'h1111);
    @(negedge net_clk);
    s_data_data[W +: W] = 64'h2222;
    #2;
    net_areset = 1'b1;
    #1;
    check_all_zero("midpkt_reset");
    @(negedge net_clk);
    clear_inputs();
    net_areset = 1'b0;
    sts_q.delete();
    model_last = int'(NA) - 1;
    for (int a = 0; a < int'(NA); a++) active[a] = 1'b0;
    pkt_len[0] = 2; pkt_len[1] = 2;
    pkt_meta[0] = 32'h0010_0000; pkt_meta[1] = 32'h0010_0001;
    run_round(4'b0011, 2, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
